// File: rtl/partition_pkg.sv
// Shared types and helpers for the partition scheduler: FSM encoding, stat width, clogb2.
package partition_pkg;

  localparam int STAT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // Bits needed to hold 'value' (at least 1).
  function automatic int clogb2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if (value >= (1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/partition_scheduler_if.sv
// Mapper-side and shared-FIFO-side signals of the partition scheduler.
interface partition_scheduler_if #(
  parameter int NUM_OF_MAPPERS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int SRC_W          = partition_pkg::clogb2(NUM_OF_MAPPERS - 1)
);

  logic [NUM_OF_MAPPERS-1:0]            mapper_empty;
  logic [NUM_OF_MAPPERS-1:0]            mapper_rd_en;
  logic [NUM_OF_MAPPERS*DATA_WIDTH-1:0] mapper_data;
  logic                                 out_afull;
  logic                                 out_wr_en;
  logic [DATA_WIDTH-1:0]                out_data;
  logic [SRC_W-1:0]                     out_src;

  modport master (
    input  mapper_empty, mapper_data, out_afull,
    output mapper_rd_en, out_wr_en, out_data, out_src
  );

  modport slave (
    output mapper_empty, mapper_data, out_afull,
    input  mapper_rd_en, out_wr_en, out_data, out_src
  );

endinterface

// File: rtl/partition_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module partition_rr_pick
  import partition_pkg::*;
#(
  parameter int N     = 4,
  parameter int SRC_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0]   rot;
  logic [N-1:0]   low;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[N-1:0];
    low    = rot & (-rot);
    back   = {low, low} << ptr;
    onehot = back[2*N-1:N];
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = SRC_W'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/partition_scheduler.sv
// Burst scheduler from N mapper FIFOs into one shared partition FIFO, tagging each word
// with its source. Per-mapper word counters are built when PARTITION_SCHED_STATS_EN is defined.
module partition_scheduler
  import partition_pkg::*;
#(
  parameter int NUM_OF_MAPPERS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_BURST      = 4,
  localparam int SRC_W         = clogb2(NUM_OF_MAPPERS - 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  partition_scheduler_if.master bus,
  output logic                  busy,
  input  logic [SRC_W-1:0]      stat_sel,
  output logic [STAT_W-1:0]     stat_count
);

  localparam int BURST_W = clogb2(MAX_BURST);
  localparam int N       = NUM_OF_MAPPERS;

  state_e              state_q, state_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [SRC_W-1:0]    gidx_q, gidx_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]  burst_q, burst_d;

  logic                rd_pend_q, rd_pend_d;
  logic [SRC_W-1:0]    src_pend_q, src_pend_d;
  logic                out_wr_en_q, out_wr_en_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0]    out_src_q, out_src_d;

  logic [N-1:0]        req;
  logic [N-1:0]        pick_onehot;
  logic [SRC_W-1:0]    pick_idx;
  logic                pick_any;
  logic                can_rd;
  logic [N-1:0]        rd_en;
  logic [SRC_W-1:0]    next_ptr;

  assign req = ~bus.mapper_empty;

  partition_rr_pick #(
    .N     (N),
    .SRC_W (SRC_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_ptr = (int'(gidx_q) == N - 1) ? '0 : gidx_q + SRC_W'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    burst_d  = burst_q;
    rr_ptr_d = rr_ptr_q;
    can_rd   = 1'b0;
    rd_en    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && !bus.out_afull) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          burst_d = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        can_rd = !bus.mapper_empty[gidx_q] && !bus.out_afull &&
                 (burst_q < BURST_W'(MAX_BURST));
        rd_en  = grant_q & {N{can_rd}};
        if (can_rd) burst_d = burst_q + BURST_W'(1);
        // Leaving XFER hands the next turn to the mapper after this one, even on backpressure.
        if (!can_rd || (burst_q == BURST_W'(MAX_BURST - 1))) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_pend_d   = |rd_en;
    src_pend_d  = gidx_q;
    out_wr_en_d = rd_pend_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (rd_pend_q) begin
      out_data_d = bus.mapper_data[src_pend_q*DATA_WIDTH +: DATA_WIDTH];
      out_src_d  = src_pend_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      burst_q     <= '0;
      rr_ptr_q    <= '0;
      rd_pend_q   <= 1'b0;
      src_pend_q  <= '0;
      out_wr_en_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      burst_q     <= burst_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_pend_q   <= rd_pend_d;
      src_pend_q  <= src_pend_d;
      out_wr_en_q <= out_wr_en_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.mapper_rd_en = rd_en;
  assign bus.out_wr_en    = out_wr_en_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_src      = out_src_q;
  assign busy             = (state_q != ST_IDLE) || rd_pend_q;

`ifdef PARTITION_SCHED_STATS_EN
  logic [STAT_W-1:0] cnt_q [N];
  logic [STAT_W-1:0] cnt_d [N];

  // Counters saturate rather than wrap so a long run never reports a small count.
  always_comb begin
    cnt_d = cnt_q;
    if (out_wr_en_q && (cnt_q[out_src_q] != {STAT_W{1'b1}})) begin
      cnt_d[out_src_q] = cnt_q[out_src_q] + STAT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_count = (int'(stat_sel) < N) ? cnt_q[stat_sel] : '0;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule
